// File: rtl/dimension_scaler.sv
// dimension_scaler: out_dim = (in_dim-1)*num/den + 1 via one multiply cycle and a radix-2 restoring divide.
module dimension_scaler #(
  parameter int COORD_BITS = 16,
  parameter int RATIO_BITS = 8,
  localparam int PW = COORD_BITS + RATIO_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COORD_BITS-1:0] in_dim,
  input  logic [RATIO_BITS-1:0] in_num,
  input  logic [RATIO_BITS-1:0] in_den,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COORD_BITS-1:0] out_dim,
  output logic                  out_error
);
  localparam int CW = $clog2(PW);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [COORD_BITS-1:0] dim;
  logic [RATIO_BITS-1:0] num, den;
  logic [PW-1:0] p, q;
  logic [RATIO_BITS:0] rem, shifted;
  logic [CW-1:0] cnt;
  logic fin, ge;
  logic [PW:0] r;
  logic [COORD_BITS-1:0] dm1;
  always_comb begin
    dm1 = (dim == '0) ? '0 : dim - 1'b1;
    shifted = {rem[RATIO_BITS-1:0], p[PW-1]};
    ge = rem[RATIO_BITS] | (shifted >= {1'b0, den});
    r = {1'b0, q} + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_dim <= '0;
      out_error <= 1'b0;
      dim <= '0;
      num <= '0;
      den <= '0;
      p <= '0;
      q <= '0;
      rem <= '0;
      cnt <= '0;
      fin <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dim <= in_dim;
          num <= in_num;
          den <= in_den;
          in_ready <= 1'b0;
          state <= MUL;
        end
        MUL: begin
          p <= PW'(dm1) * PW'(num);
          q <= '0;
          rem <= '0;
          cnt <= CW'(PW - 1);
          fin <= 1'b0;
          state <= DIV;
        end
        // after the last quotient bit, one extra cycle resolves the result from the registered quotient
        DIV: if (fin) begin
          out_dim <= (den == '0) ? '1 : (dim == '0) ? '0 : (|r[PW:COORD_BITS]) ? '1 : r[COORD_BITS-1:0];
          out_error <= (den == '0) || ((dim != '0) && (|r[PW:COORD_BITS]));
          out_valid <= 1'b1;
          state <= DONE;
        end else begin
          p <= p << 1;
          q <= {q[PW-2:0], ge};
          rem <= ge ? shifted - {1'b0, den} : shifted;
          cnt <= cnt - 1'b1;
          fin <= (cnt == '0);
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dimension_scaler.sv
// tb_dimension_scaler: directed table, sampled sweep, random ratios, stall and mid-divide reset.
module tb_dimension_scaler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_dim = '0;
  logic [7:0] in_num = '0, in_den = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [15:0] out_dim;
  logic out_error;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] dim;
    logic [7:0] num;
    logic [7:0] den;
    logic [15:0] exp_dim;
    logic exp_err;
  } vec_t;
  vec_t vecs[14];
  dimension_scaler dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dim(in_dim), .in_num(in_num), .in_den(in_den), .out_valid(out_valid),
    .out_ready(out_ready), .out_dim(out_dim), .out_error(out_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void model(input logic [15:0] d, input logic [7:0] n, input logic [7:0] dn,
                                output logic [15:0] od, output logic oe);
    longint v;
    if (dn == 0) begin od = 16'hFFFF; oe = 1'b1; end
    else if (d == 0) begin od = 16'h0; oe = 1'b0; end
    else begin
      v = (longint'(d) - 1) * longint'(n) / longint'(dn) + 1;
      if (v > 65535) begin od = 16'hFFFF; oe = 1'b1; end
      else begin od = 16'(v); oe = 1'b0; end
    end
  endfunction
  task automatic run(input logic [15:0] d, input logic [7:0] n, input logic [7:0] dn,
                     input logic [15:0] ed, input logic ee, input string tag);
    int lat;
    @(negedge clk);
    in_dim = d; in_num = n; in_den = dn; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_dim = 16'($urandom); in_num = 8'($urandom); in_den = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 100);
    check({tag, "_latency"}, lat, 26);
    check({tag, "_dim"}, out_dim, ed);
    check({tag, "_err"}, out_error, ee);
    @(posedge clk);
    #1 check({tag, "_taken"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask
  initial begin
    logic [15:0] md, rd;
    logic me;
    logic [7:0] rn, rdn;
    int seen, lat;
    vecs[0]  = '{16'd6,     8'd4,   8'd5,   16'd5,     1'b0};
    vecs[1]  = '{16'd0,     8'd4,   8'd5,   16'd0,     1'b0};
    vecs[2]  = '{16'd1,     8'd7,   8'd3,   16'd1,     1'b0};
    vecs[3]  = '{16'd100,   8'd4,   8'd0,   16'hFFFF,  1'b1};
    vecs[4]  = '{16'd65535, 8'd2,   8'd1,   16'hFFFF,  1'b1};
    vecs[5]  = '{16'd32768, 8'd2,   8'd1,   16'd65535, 1'b0};
    vecs[6]  = '{16'd10,    8'd4,   8'd5,   16'd8,     1'b0};
    vecs[7]  = '{16'd1920,  8'd1,   8'd2,   16'd960,   1'b0};
    vecs[8]  = '{16'd255,   8'd255, 8'd1,   16'd64771, 1'b0};
    vecs[9]  = '{16'd100,   8'd0,   8'd7,   16'd1,     1'b0};
    vecs[10] = '{16'd1000,  8'd3,   8'd7,   16'd429,   1'b0};
    vecs[11] = '{16'd65535, 8'd255, 8'd255, 16'd65535, 1'b0};
    vecs[12] = '{16'd65535, 8'd1,   8'd255, 16'd257,   1'b0};
    vecs[13] = '{16'd0,     8'd9,   8'd0,   16'hFFFF,  1'b1};
    repeat (3) @(posedge clk);
    #1 check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_dim", out_dim, 0);
    check("rst_out_error", out_error, 0);
    @(negedge clk) reset_n = 1'b1;
    foreach (vecs[i]) run(vecs[i].dim, vecs[i].num, vecs[i].den, vecs[i].exp_dim, vecs[i].exp_err, $sformatf("vec%0d", i));
    for (int i = 0; i < 255; i++) begin
      rd = 16'(1 + i * 257);
      model(rd, 8'd4, 8'd5, md, me);
      run(rd, 8'd4, 8'd5, md, me, $sformatf("sweep_%0d", rd));
    end
    model(16'd65535, 8'd4, 8'd5, md, me);
    run(16'd65535, 8'd4, 8'd5, md, me, "sweep_65535");
    for (int i = 0; i < 150; i++) begin
      rd = 16'($urandom);
      rn = 8'($urandom_range(1, 255));
      rdn = 8'($urandom_range(1, 255));
      model(rd, rn, rdn, md, me);
      run(rd, rn, rdn, md, me, $sformatf("rand_%0d_%0d_%0d", rd, rn, rdn));
    end
    // stall: result held while out_ready is low, new requests ignored
    @(negedge clk);
    in_dim = 16'd10; in_num = 8'd4; in_den = 8'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 100);
    check("stall_latency", lat, 26);
    in_dim = 16'd500; in_num = 8'd9; in_den = 8'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check($sformatf("stall_valid_%0d", i), out_valid, 1);
      check($sformatf("stall_dim_%0d", i), out_dim, 8);
      check($sformatf("stall_err_%0d", i), out_error, 0);
      check($sformatf("stall_in_ready_%0d", i), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("stall_release", out_valid, 0);
    check("stall_ready_back", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 seen += int'(out_valid);
    end
    check("stall_ignored_req", seen, 0);
    // reset during the divide aborts immediately
    @(negedge clk);
    in_dim = 16'd1000; in_num = 8'd3; in_den = 8'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    #1 check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_dim", out_dim, 0);
    check("abort_out_error", out_error, 0);
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1 seen += int'(out_valid);
    end
    check("abort_dropped", seen, 0);
    run(16'd6, 8'd4, 8'd5, 16'd5, 1'b0, "post_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
